// File: rtl/inp_hazard_check.sv
// inp_hazard_check
//   Front-panel instruction loader plus static data-hazard checker for the
//   8-bit, 5-stage core. Each toggle of the load button stores one switch
//   value into the next of eight instruction slots. A combinational scan of
//   the slot image, registered once, reports RAW/WAW hazards per slot.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   input_val      in   8   switch value (instruction to load)
//   but_inp        in   1   asynchronous load button; each edge loads one slot
//   instrMemBits   out  64  instruction image, slot k at [8k+7:8k]
//   hazardMemBits  out  64  hazard report, byte k describes slot k
//
// Instruction format: [7:6] opcode, [5:3] rd, [2:0] rs; 8'hFF is HALT/empty.
// Hazard byte: bit0 RAW1, bit1 RAW2, bit2 WAW1, [4:3] stall count, [7:5] zero.
//
// There is no valid/ready handshake here: the button is a free-running level
// and every change of it, once synchronized, is a one-cycle load event.

module inp_hazard_check #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  input_val,
    input  logic        but_inp,
    output logic [63:0] instrMemBits,
    output logic [63:0] hazardMemBits
);

    localparam int SLOTS = 8;

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;   // previous synchronized level
    logic                   load_evt;
    logic [2:0]             ptr_q;
    logic                   locked_q;
    logic [63:0]            instr_q;

    // A button edge reaches sync_q[last] after SYNC_STAGES cycles and is
    // compared against the level one cycle older, so the write lands
    // SYNC_STAGES+1 edges after the toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q[0] <= but_inp;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign load_evt = sync_q[SYNC_STAGES-1] ^ last_q;

    // Lock after the last slot is written or after a HALT is stored; the
    // pointer stays on the last slot rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= {64{1'b1}};
            ptr_q    <= 3'd0;
            locked_q <= 1'b0;
        end else if (load_evt && !locked_q) begin
            instr_q[{ptr_q, 3'b000} +: 8] <= input_val;
            if (ptr_q == 3'd7) begin
                locked_q <= 1'b1;
            end else begin
                ptr_q <= ptr_q + 3'd1;
            end
            if (input_val == 8'hFF) begin
                locked_q <= 1'b1;
            end
        end
    end

    assign instrMemBits = instr_q;

    // ------------------------------------------------------------------
    // Hazard checker
    // ------------------------------------------------------------------
    logic [SLOTS-1:0]      vld;
    logic [SLOTS-1:0][2:0] rd;
    logic [SLOTS-1:0][2:0] rs;
    logic [63:0]           hz_d;
    logic [63:0]           hz_q;

    for (genvar k = 0; k < SLOTS; k++) begin : g_decode
        assign vld[k] = (instr_q[8*k +: 8] != 8'hFF);
        assign rd[k]  = instr_q[8*k+3 +: 3];
        assign rs[k]  = instr_q[8*k   +: 3];
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k == 0) begin : g_first
            // Nothing precedes slot 0, so it can never be hazarded.
            assign hz_d[7:0] = 8'h00;
        end else begin : g_rest
            logic       raw1;
            logic       raw2;
            logic       waw1;
            logic [1:0] stall;

            assign raw1 = vld[k] && vld[k-1] && (rs[k] == rd[k-1]);
            assign waw1 = vld[k] && vld[k-1] && (rd[k] == rd[k-1]);
            if (k >= 2) begin : g_raw2
                assign raw2 = vld[k] && vld[k-2] && (rs[k] == rd[k-2]);
            end else begin : g_no_raw2
                assign raw2 = 1'b0;
            end

            // The nearer producer dominates: one bubble fewer per distance.
            assign stall = raw1 ? 2'd2 : (raw2 ? 2'd1 : 2'd0);

            assign hz_d[8*k +: 8] = {3'b000, stall, waw1, raw2, raw1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_q <= '0;
        end else begin
            hz_q <= hz_d;
        end
    end

    assign hazardMemBits = hz_q;

endmodule

// File: tb/tb_inp_hazard_check.sv
// Directed bench for inp_hazard_check: reset values, a full program load with
// HALT lock, RAW2 detection, 8-slot saturation, and asynchronous reset during
// a load sequence. Expected values are hand-computed from the instruction
// format.

`timescale 1ns/1ps

module tb_inp_hazard_check;

    localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [7:0]  input_val;
    logic        but_inp;
    logic [63:0] instrMemBits;
    logic [63:0] hazardMemBits;

    int n_checks;
    int n_fail;

    logic [63:0] exp_q[$];
    logic [63:0] exp_img;
    logic [63:0] exp_val;

    inp_hazard_check #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_val     (input_val),
        .but_inp       (but_inp),
        .instrMemBits  (instrMemBits),
        .hazardMemBits (hazardMemBits)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset for a few cycles; the button is returned to 0 while in
    // reset, which must not count as a load.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        but_inp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Toggle the button with a new value, then wait past the write (edge 3)
    // and the registered hazard update (edge 4).
    task automatic load(input logic [7:0] v);
        @(posedge clk);
        #1;
        input_val = v;
        but_inp   = ~but_inp;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] prog1 [8];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        but_inp   = 1'b0;
        input_val = 8'h00;
        prog1 = '{8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'hFF};

        // Reset only.
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_in_reset", instrMemBits, ALL_FF);
        check("rst_hazard_in_reset", hazardMemBits, 64'h0);
        do_reset();
        check("rst_instr", instrMemBits, ALL_FF);
        check("rst_hazard", hazardMemBits, 64'h0);

        // Test 1: full program with latency checks on slot 1.
        exp_img = ALL_FF;
        for (int i = 0; i < 8; i++) begin
            exp_img[8*i +: 8] = prog1[i];
            exp_q.push_back(exp_img);
        end

        load(prog1[0]);
        exp_val = exp_q.pop_front();
        check("t1_slot0", instrMemBits, exp_val);

        @(posedge clk);
        #1;
        input_val = prog1[1];
        but_inp   = ~but_inp;
        repeat (2) @(posedge clk);
        #1;
        check("t1_lat_not_yet", instrMemBits, exp_val);
        @(posedge clk);
        #1;
        exp_val = exp_q.pop_front();
        check("t1_lat_write", instrMemBits, exp_val);
        check("t1_lat_hz_old", hazardMemBits, 64'h0);
        @(posedge clk);
        #1;
        check("t1_lat_hz_new", hazardMemBits, 64'h0000_0000_0000_1500);

        for (int i = 2; i < 8; i++) begin
            load(prog1[i]);
            exp_val = exp_q.pop_front();
            check($sformatf("t1_slot%0d", i), instrMemBits, exp_val);
        end
        check("t1_image", instrMemBits, 64'hFF89A8908C8A8988);
        check("t1_hazard", hazardMemBits, 64'h0000000004041500);

        // Locked after HALT.
        load(8'h11);
        check("lock_instr", instrMemBits, 64'hFF89A8908C8A8988);
        check("lock_hazard", hazardMemBits, 64'h0000000004041500);

        // Test 2: RAW2 detection.
        do_reset();
        load(8'h08);
        load(8'h20);
        load(8'h01);
        check("t2_image", instrMemBits, 64'hFFFF_FFFF_FF01_2008);
        check("t2_hazard", hazardMemBits, 64'h0000_0000_000A_0000);

        // Test 3: eight non-HALT writes, ninth ignored.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            load(i[7:0]);
        end
        check("t3_full", instrMemBits, 64'h0807060504030201);
        load(8'h55);
        check("t3_ninth_ignored", instrMemBits, 64'h0807060504030201);
        load(8'h66);
        check("t3_tenth_ignored", instrMemBits, 64'h0807060504030201);

        // Test 4: asynchronous reset after three writes.
        do_reset();
        load(8'h11);
        load(8'h22);
        load(8'h33);
        check("t4_pre_image", instrMemBits, 64'hFFFF_FFFF_FF33_2211);
        check("t4_pre_hazard", hazardMemBits, 64'h0000_0000_0000_1100);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_async_instr", instrMemBits, ALL_FF);
        check("t4_async_hazard", hazardMemBits, 64'h0);
        but_inp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_spurious", instrMemBits, ALL_FF);
        load(8'h42);
        check("t4_slot0_again", instrMemBits, 64'hFFFF_FFFF_FFFF_FF42);
        check("t4_hazard_after", hazardMemBits, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
